// File: rtl/sumador_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sumador_pkg
// Brief   : Shared types and constants for the bit-serial adder/subtractor.
// Revision: 1.0 - initial release
// ============================================================================
package sumador_pkg;

    localparam int DEFAULT_WIDTH = 8;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/full_adder_bit.sv
`default_nettype none
// ============================================================================
// Module  : full_adder_bit
// Brief   : Single combinational full-adder cell shared by every bit position.
// Revision: 1.0 - initial release
// ============================================================================
module full_adder_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule
`default_nettype wire

// File: rtl/sumador_serial.sv
`default_nettype none
// ============================================================================
// Module  : sumador_serial
// Brief   : Bit-serial adder/subtractor, LSB first, one full-adder cell.
// Revision: 1.0 - initial release
// ============================================================================
module sumador_serial
    import sumador_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             acc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int               CNT_W    = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_sum;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_carry;
    logic               r_cout;
    logic               r_ovf;
    logic               r_out_valid;
    logic               w_accept;
    logic               w_last;
    logic               w_fa_s;
    logic               w_fa_cout;
    logic [WIDTH-1:0]   w_a_shifted;

    assign w_accept    = in_valid && (r_state == IDLE);
    assign w_last      = (r_cnt == LAST_BIT);
    // Result bits enter at the top of A as its operand bits leave at the bottom.
    assign w_a_shifted = {w_fa_s, r_a[WIDTH-1:1]};

    full_adder_bit u_fa (
        .a    (r_a[0]),
        .b    (r_b[0]),
        .cin  (r_carry),
        .s    (w_fa_s),
        .cout (w_fa_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept)  w_state_nxt = SHIFT;
            SHIFT:   if (w_last)    w_state_nxt = DONE;
            DONE:    if (out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a         <= '0;
            r_b         <= '0;
            r_sum       <= '0;
            r_cnt       <= '0;
            r_carry     <= 1'b0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= (w_state_nxt == DONE);
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_a     <= acc ? r_sum : a;
                        r_b     <= (sub == OP_SUB) ? ~b : b;
                        r_carry <= (sub == OP_SUB);
                        r_cnt   <= '0;
                    end
                end
                SHIFT: begin
                    r_a     <= w_a_shifted;
                    r_b     <= {1'b0, r_b[WIDTH-1:1]};
                    r_carry <= w_fa_cout;
                    if (w_last) begin
                        // r_carry here is the carry into the MSB.
                        r_sum  <= w_a_shifted;
                        r_cout <= w_fa_cout;
                        r_ovf  <= r_carry ^ w_fa_cout;
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE) && !rst;
    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;

endmodule
`default_nettype wire
